// File: rtl/tbu_if.sv
// tbu_if: step/decision and decoded-bit bundle between the ACSU/PMU and the TBU.
//   valid_i      : a decision vector for one trellis step is present
//   ready_o      : TBU can accept a step
//   dec_i        : survivor decision bit per state s0..s3
//   pm_s0_i..s3_i: normalised path metrics from the PMU
//   bit_o        : decoded bit
//   bit_valid_o  : one-cycle strobe qualifying bit_o
//   best_state_o : best state latched for the current traceback
// Modports: slave = TBU side, master = ACSU/PMU (or bench) side.
interface tbu_if #(
    parameter int PM_WIDTH = 8
);
    logic                valid_i;
    logic                ready_o;
    logic [3:0]          dec_i;
    logic [PM_WIDTH-1:0] pm_s0_i;
    logic [PM_WIDTH-1:0] pm_s1_i;
    logic [PM_WIDTH-1:0] pm_s2_i;
    logic [PM_WIDTH-1:0] pm_s3_i;
    logic                bit_o;
    logic                bit_valid_o;
    logic [1:0]          best_state_o;

    modport slave (
        input  valid_i, dec_i, pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i,
        output ready_o, bit_o, bit_valid_o, best_state_o
    );

    modport master (
        output valid_i, dec_i, pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i,
        input  ready_o, bit_o, bit_valid_o, best_state_o
    );
endinterface

// File: rtl/tbu.sv
// tbu: traceback unit for the 4-state (K=3, rate-1/2) Viterbi decoder.
// Stores per-step survivor decisions in a circular memory of depth TBL, picks
// the minimum-metric state one cycle after each accepted step, and once the
// window is full traces back TBL-1 steps to emit one decoded bit per step.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active low
//   bus   : tbu_if.slave (valid/ready, decisions, path metrics, decoded bit)
module tbu #(
    parameter int TBL      = 15,
    parameter int PM_WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    tbu_if.slave  bus
);
    localparam int PW = $clog2(TBL);
    localparam int CW = $clog2(TBL + 1);

    typedef enum logic [1:0] {IDLE, BEST, TRACE, OUT} state_t;

    state_t              r_fsm;
    state_t              w_fsm_nxt;
    logic [3:0]          r_mem [TBL];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       r_step;
    logic [1:0]          r_trace;
    logic [1:0]          r_best;
    logic                r_bit;
    logic                r_bit_valid;
    logic                w_accept;
    logic [1:0]          w_best;
    logic [PM_WIDTH-1:0] w_best_pm;
    logic                w_dec_bit;
    logic [1:0]          w_trace_nxt;

    assign w_accept = bus.valid_i && (r_fsm == IDLE);

    // Strict '<' scan in index order keeps the lowest index on ties.
    always_comb begin
        w_best    = 2'd0;
        w_best_pm = bus.pm_s0_i;
        if (bus.pm_s1_i < w_best_pm) begin w_best = 2'd1; w_best_pm = bus.pm_s1_i; end
        if (bus.pm_s2_i < w_best_pm) begin w_best = 2'd2; w_best_pm = bus.pm_s2_i; end
        if (bus.pm_s3_i < w_best_pm) begin w_best = 2'd3; w_best_pm = bus.pm_s3_i; end
    end

    // Predecessor of s with decision d is {s[0], d}.
    assign w_dec_bit   = r_mem[r_rd_ptr][r_trace];
    assign w_trace_nxt = {r_trace[0], w_dec_bit};

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:    if (bus.valid_i) w_fsm_nxt = BEST;
            BEST:    w_fsm_nxt = (r_count < CW'(TBL)) ? IDLE : TRACE;
            TRACE:   if (r_step == CW'(1)) w_fsm_nxt = OUT;
            OUT:     w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // Survivor memory is not reset; r_count gates whether its contents are used.
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= bus.dec_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_step      <= '0;
            r_trace     <= '0;
            r_best      <= '0;
            r_bit       <= 1'b0;
            r_bit_valid <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_bit_valid <= 1'b0;
            case (r_fsm)
                IDLE: if (w_accept) begin
                    r_rd_ptr <= r_wr_ptr;
                    r_wr_ptr <= (r_wr_ptr == PW'(TBL - 1)) ? '0 : r_wr_ptr + PW'(1);
                    if (r_count != CW'(TBL)) r_count <= r_count + CW'(1);
                end
                BEST: begin
                    r_trace <= w_best;
                    r_best  <= w_best;
                    r_step  <= CW'(TBL - 1);
                end
                TRACE: begin
                    r_trace  <= w_trace_nxt;
                    r_rd_ptr <= (r_rd_ptr == '0) ? PW'(TBL - 1) : r_rd_ptr - PW'(1);
                    r_step   <= r_step - CW'(1);
                    // Last trace step: register the bit so it lines up with the OUT strobe.
                    if (r_step == CW'(1)) begin
                        r_bit       <= w_trace_nxt[1];
                        r_bit_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o      = (r_fsm == IDLE);
    assign bus.bit_o        = r_bit;
    assign bus.bit_valid_o  = r_bit_valid;
    assign bus.best_state_o = r_best;
endmodule

// File: tb/tb_tbu.sv
module tb_tbu;
    localparam int TBL = 15;

    typedef struct {
        logic       b;
        logic [1:0] best;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    tbu_if #(.PM_WIDTH(8)) bus ();

    tbu #(.TBL(TBL), .PM_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t       q[$];
    logic       hist[$];
    int         n_acc;
    int         n_strobe;
    logic [1:0] ts;
    bit         no_push;
    int         errs   = 0;
    int         checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.bit_valid_o) begin
                n_strobe++;
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_strobe: bit_o=%0d with no pending expectation (cycle %0d)",
                             bus.bit_o, cyc);
                end else begin
                    e = q.pop_front();
                    check("bit_o", int'(bus.bit_o), int'(e.b));
                    check("best_state_at_strobe", int'(bus.best_state_o), int'(e.best));
                    check("strobe_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.valid_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ts = 2'd0; hist.delete(); n_acc = 0; q.delete(); n_strobe = 0;
    endtask

    // Entered just after a negedge; returns at the negedge following the BEST cycle.
    task automatic send(input logic [3:0] dec, input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] p2, input logic [7:0] p3, input logic u,
                        input logic [1:0] best, input bit hold);
        bit   r;
        bit   got;
        exp_t e;
        bus.dec_i = dec;
        bus.pm_s0_i = p0; bus.pm_s1_i = p1; bus.pm_s2_i = p2; bus.pm_s3_i = p3;
        bus.valid_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r = bus.ready_o;
            @(negedge clk);
            if (r) begin got = 1'b1; break; end
        end
        if (!got) begin
            checks++; errs++;
            $display("FAIL accept_timeout: ready_o never high within 40 cycles (cycle %0d)", cyc);
            bus.valid_i = 1'b0;
            return;
        end
        // Now in the BEST cycle of this step.
        check("ready_low_in_best", int'(bus.ready_o), 0);
        hist.push_back(u);
        n_acc++;
        if (n_acc >= TBL && !no_push) begin
            e.b = hist[n_acc - TBL];
            e.best = best;
            e.cyc = (cyc - 1) + TBL + 1;
            q.push_back(e);
        end
        if (!hold) bus.valid_i = 1'b0;
        @(negedge clk);
        check("best_state_o", int'(bus.best_state_o), int'(best));
    endtask

    // Golden path model: true state follows next={u,s[1]}; the survivor decision of the
    // true new state points back at the true predecessor, other states get filler
    // decisions, and only the true state carries the minimum metric.
    task automatic send_u(input logic u, input bit hold);
        logic [1:0] ns;
        logic [3:0] dec;
        logic [7:0] pm[4];
        ns = {u, ts[1]};
        dec = 4'((n_acc * 7) + 3);
        dec[ns] = ts[0];
        for (int s = 0; s < 4; s++) pm[s] = 8'(1 + ((n_acc * 37 + s * 53) % 200));
        pm[ns] = 8'd0;
        ts = ns;
        send(dec, pm[0], pm[1], pm[2], pm[3], u, ns, hold);
    endtask

    task automatic drain(input string name, input int exp_strobes);
        repeat (TBL + 6) @(negedge clk);
        while (q.size() > 0) begin
            void'(q.pop_front());
            checks++; errs++;
            $display("FAIL missing_strobe_%s: expected strobe never seen", name);
        end
        check({"strobe_count_", name}, n_strobe, exp_strobes);
    endtask

    initial begin
        logic [11:0] pat;
        logic [39:0] rnd;
        pat = 12'b0111_0100_1101; // u = 1,0,1,1,0,0,1,0,1,1,1,0 read LSB first
        rnd = 40'hB53C9E71D4;
        bus.valid_i = 1'b0;
        bus.dec_i = 4'h0;
        bus.pm_s0_i = 8'd0; bus.pm_s1_i = 8'd0; bus.pm_s2_i = 8'd0; bus.pm_s3_i = 8'd0;
        no_push = 1'b0;
        fork monitor(); join_none

        // Reset state
        do_reset();
        check("reset_ready_o", int'(bus.ready_o), 1);
        check("reset_bit_valid_o", int'(bus.bit_valid_o), 0);
        check("reset_bit_o", int'(bus.bit_o), 0);
        check("reset_best_state_o", int'(bus.best_state_o), 0);

        // All-zero stream: 20 steps -> 6 strobes of 0
        for (int k = 0; k < 20; k++) send(4'h0, 8'd0, 8'd128, 8'd128, 8'd128, 1'b0, 2'd0, 1'b0);
        drain("allzero", 6);

        // Tie-break on the best-state search
        do_reset();
        send(4'h0, 8'd5, 8'd5, 8'd5, 8'd5, 1'b0, 2'd0, 1'b0);
        send(4'h0, 8'd9, 8'd3, 8'd3, 8'd7, 1'b0, 2'd1, 1'b0);
        drain("tie", 0);

        // Noiseless stream through the path model
        do_reset();
        for (int k = 0; k < 30; k++) send_u(pat[k % 12], 1'b0);
        drain("stream", 16);

        // valid_i held high continuously
        do_reset();
        for (int k = 0; k < 20; k++) send_u(rnd[k], 1'b1);
        bus.valid_i = 1'b0;
        drain("holdvalid", 6);

        // Reset in the middle of a full-window traceback
        do_reset();
        for (int k = 0; k < 14; k++) send_u(pat[k % 12], 1'b0);
        no_push = 1'b1;
        send_u(1'b1, 1'b0);
        no_push = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("ready_after_midreset", int'(bus.ready_o), 1);
        check("no_strobe_after_midreset", int'(bus.bit_valid_o), 0);
        ts = 2'd0; hist.delete(); n_acc = 0; q.delete(); n_strobe = 0;
        for (int k = 0; k < 15; k++) send_u(rnd[k + 5], 1'b0);
        drain("midreset", 1);

        // 40 steps of pseudo-random u, exercising pointer wraps
        do_reset();
        for (int k = 0; k < 40; k++) send_u(rnd[39 - k], 1'b0);
        drain("wrap", 26);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
